sensor_encoder: RTL
===================

Name: sensor_encoder

Overview:
- Front end that produces the 3-bit `sensor` code consumed by the gate/traffic-light FSM.
- Synchronizes and debounces two raw loop detectors: R (right loop) and L (left loop).
- Tracks which loop a vehicle entered first (direction) and flags a stuck-loop fault.
- Drives a registered `sensor` code plus a one-cycle change strobe.

Parameters:
- DEB_CYCLES, 4: consecutive cycles a synchronized input must differ from its debounced state before that state flips (>=1).
- STUCK_CYCLES, 64: consecutive cycles with both debounced loops active before fault is declared (>=2).

Ports:
- clk  input  1  system clock, all flops on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears every register immediately.
- loop_r_raw  input  1  raw right-loop detector, asynchronous to clk, active-high.
- loop_l_raw  input  1  raw left-loop detector, asynchronous to clk, active-high.
- sensor  output  3  registered code to the gate FSM (encoding below).
- sensor_chg  output  1  one-cycle pulse when `sensor` changes value.
- fault  output  1  high while in FAULT state.

Behaviour:
- Reset values: sensor=000, sensor_chg=0, fault=0, synchronizer flops=0, debounced r/l=0, dir=0, all counters=0, state=IDLE.
- Synchronizer: 2-flop chain per raw input.
- Debounce, per channel:
  - counter increments while the sync value != the debounced value; clears when they are equal.
  - When the counter reaches DEB_CYCLES-1 and the values still differ, the debounced value flips and the counter clears.
  - Any glitch shorter than DEB_CYCLES cycles is ignored.
- Latency: raw edge to `sensor` update is 2 (sync) + DEB_CYCLES + 1 (output register) cycles.
- dir register (0 = entered from right, 1 = entered from left). It updates only on a transition out of "both debounced loops 0":
  - r alone rises: dir=0.
  - l alone rises: dir=1.
  - both rise in the same cycle: dir unchanged.
  - Otherwise dir holds.
- Encoding, registered from the next-cycle debounced values, state and dir:
  - IDLE (r=0, l=0): 000.
  - only r: {dir,0,1}, i.e. 001 or 101.
  - only l: {dir,1,0}, i.e. 010 or 110.
  - both, not FAULT: 011 (dir not shown).
  - FAULT: 111. Code 111 is reserved for fault and never otherwise produced.
- States:
  - IDLE: both loops 0.
  - OCC: any loop 1.
  - FAULT.
  - IDLE->OCC on any debounced loop becoming 1.
  - OCC->IDLE when both become 0.
- Stuck counter:
  - counts cycles with r=1 and l=1 in OCC.
  - clears whenever either loop is 0.
  - saturates.
  - When the count reaches STUCK_CYCLES: OCC->FAULT.
- FAULT:
  - sensor=111, fault=1.
  - Loop changes are ignored until both debounced loops are 0.
  - Then FAULT->IDLE, sensor=000, fault=0, dir=0, stuck counter=0.
  - Single-loop states seen during FAULT do not exit it.
- sensor_chg:
  - asserts the cycle after the `sensor` register takes a new value, aligned with the new value, for exactly one cycle.
  - never asserts on reset or reset release.
  - back-to-back changes give back-to-back pulses.
- Reset mid-operation: async clear of all state, including FAULT and partial debounce counts. The first post-reset loop edge again needs the full sync + debounce latency.
- Counter widths: $clog2 of the parameter plus 1; no wrap.

Test Plan:
Bench parameters: DEB_CYCLES=4, STUCK_CYCLES=16. Cycle counts are from the raw edge.
1. Right-to-left pass: R raw 1, then L 1, then R 0, then L 0, each held 20 cycles.
   - sensor = 001 -> 011 -> 010 -> 000.
   - each transition 7 cycles after its raw edge.
   - 4 sensor_chg pulses total.
2. Left-to-right pass: L 1, R 1, L 0, R 0.
   - sensor = 010 is never produced; sequence is 110 -> 011 -> 101 -> 000.
   - dir=1 is shown on the single-loop codes.
3. Glitch rejection: R raw pulses high for 3 cycles, repeated.
   - sensor stays 000, no sensor_chg.
   - a 4-cycle pulse gives 001 then 000.
4. Stuck fault: both raw 1 for 40 cycles, then R 0 for 20 cycles, then L 0.
   - sensor 011 appears, then 111 with fault=1 after 16 cycles in 011.
   - stays 111 while R drops.
   - 000 with fault=0 after L clears.
5. Simultaneous entry: after test 2 (dir=1), both raw rise in the same cycle, then R drops.
   - sensor 011 then 110 (dir retained).
6. Reset mid-operation: assert reset while sensor=111.
   - sensor, fault and sensor_chg all 0 asynchronously, before the next clk edge.
   - after release with both raw 1, 011 appears again after 7 cycles.

Source files
------------

// File: rtl/sensor_encoder.sv
// rtl/sensor_encoder.sv - loop detector sync/debounce, entry direction, stuck fault and sensor code
module sensor_encoder #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loop_r_raw,
  input  logic       loop_l_raw,
  output logic [2:0] sensor,
  output logic       sensor_chg,
  output logic       fault
);

  localparam int DCW = $clog2(DEB_CYCLES) + 1;
  localparam int SCW = $clog2(STUCK_CYCLES) + 1;
  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
  localparam logic [SCW-1:0] STUCK_MAX = SCW'(STUCK_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OCC   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  // Loop vectors: bit 0 = right loop, bit 1 = left loop
  logic [1:0]     sync1_q, sync1_d;
  logic [1:0]     sync2_q, sync2_d;
  logic [1:0]     deb_q, deb_d;
  logic [DCW-1:0] cnt_q [2];
  logic [DCW-1:0] cnt_d [2];
  logic [SCW-1:0] stuck_q, stuck_d;
  state_e         state_q, state_d;
  logic           dir_q, dir_d;
  logic [2:0]     sensor_q, sensor_d;
  logic           chg_q, chg_d;

  always_comb begin
    sync1_d = {loop_l_raw, loop_r_raw};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d[0] = '0;
    cnt_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    stuck_d = '0;
    if (deb_q == 2'b11) begin
      stuck_d = (stuck_q == STUCK_MAX) ? stuck_q : stuck_q + 1'b1;
    end

    case (state_q)
      S_IDLE: if (deb_q != 2'b00) state_d = S_OCC;
      S_OCC: begin
        if (deb_q == 2'b00) begin
          state_d = S_IDLE;
        end else if (stuck_q == STUCK_MAX) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (deb_q == 2'b00) begin
          state_d = S_IDLE;
          dir_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Direction latches only when leaving the empty state; a simultaneous rise keeps it
    if (deb_q == 2'b00) begin
      if (deb_d == 2'b01) begin
        dir_d = 1'b0;
      end else if (deb_d == 2'b10) begin
        dir_d = 1'b1;
      end
    end

    sensor_d = 3'b000;
    case (state_d)
      S_OCC: begin
        case (deb_q)
          2'b01:   sensor_d = {dir_q, 2'b01};
          2'b10:   sensor_d = {dir_q, 2'b10};
          2'b11:   sensor_d = 3'b011;
          default: sensor_d = 3'b000;
        endcase
      end
      S_FAULT: sensor_d = 3'b111;
      default: sensor_d = 3'b000;
    endcase

    chg_d = (sensor_d != sensor_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      stuck_q  <= '0;
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      sensor_q <= 3'b000;
      chg_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      stuck_q  <= stuck_d;
      state_q  <= state_d;
      dir_q    <= dir_d;
      sensor_q <= sensor_d;
      chg_q    <= chg_d;
    end
  end

  assign sensor     = sensor_q;
  assign sensor_chg = chg_q;
  assign fault      = (state_q == S_FAULT);

endmodule
